conv_mac: RTL and testbench
===========================

Name: conv_mac

Overview:
- Convolution dot-product stage directly downstream of the shift-window stage.
- Accepts one LEN-element data window plus a LEN-element kernel over a valid/ready handshake.
- Computes sum(window[i]*kernel[i]) serially, one multiply-accumulate per cycle.
- Presents the result on a valid/ready output toward the result sink.

Parameters:
- LEN, 8, number of taps (window/kernel elements); must be >= 2.
- WIDTH, 16, bits per data/kernel element; unsigned.
- RES_WIDTH, 2*WIDTH+$clog2(LEN), accumulator/result width; default 35, which is overflow-free.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_data  input  LEN*WIDTH  window; element i = in_data[i*WIDTH +: WIDTH]; element 0 is the oldest sample.
- kernel  input  LEN*WIDTH  coefficients; same packing as in_data.
- in_valid  input  1  upstream window valid.
- in_ready  output  1  block can accept a window.
- out_data  output  RES_WIDTH  dot-product result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0.
  - Accumulator and tap counter are cleared.
  - Any in-flight computation is discarded; no partial result is ever presented.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1, the window and kernel are copied into internal registers, acc<=0, cnt<=0, state<=CALC, in_ready<=0.
  - The in_data/kernel inputs are don't-care after the acceptance edge.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= acc + win[cnt]*kern[cnt], using an unsigned WIDTH x WIDTH product zero-extended to RES_WIDTH; cnt <= cnt+1.
  - On the edge processing cnt==LEN-1: out_data <= final sum, out_valid <= 1, state <= DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1; out_data is held stable until the handshake.
  - On an edge with out_ready=1: out_valid<=0, in_ready<=1, state<=IDLE.
  - If out_ready=0, hold indefinitely.
  - out_ready arriving in IDLE or CALC has no effect.
- Latency: acceptance edge T; out_valid rises after edge T+LEN.
- Throughput: minimum LEN+2 cycles per window. There is no overlap: in_ready stays 0 from acceptance until the result handshake completes.
- All outputs are registered; in_ready and out_valid are never high in the same cycle.
- Arithmetic:
  - Unsigned only; no saturation, since RES_WIDTH guarantees no overflow.
  - If RES_WIDTH is overridden smaller, the result wraps modulo 2^RES_WIDTH.
- cnt width is $clog2(LEN); it never wraps within a computation.
- Synthesis uses one multiplier, time-shared across taps.

Test Plan:
- Basic dot product: after reset, window = 1,2,3,4,5,6,7,8 and kernel all 1, with out_ready=1 → out_valid high exactly 8 cycles after acceptance with out_data=36, then in_ready=1 the following cycle.
- Full-scale: all window and kernel elements 0xFFFF → out_data = 34358689800 (0x7FFF00008), with no overflow at RES_WIDTH=35.
- Backpressure: window 2,0,0,0,0,0,0,3 with kernel 5,0,0,0,0,0,0,7 and out_ready=0 for 10 cycles → out_data=31 is held stable with out_valid=1 and in_ready=0 throughout; the handshake completes on the first out_ready=1 edge.
- Input change after accept: in_data is driven to all 0xAAAA during CALC → result still reflects the captured window; in_valid pulses during CALC/DONE are not accepted.
- Reset mid-operation: rst is driven low at cycle 3 of CALC → out_valid=0, in_ready=1, out_data=0 immediately; the next window (all 2, kernel all 3) yields 48 with no residue.
- Back-to-back: in_valid held high with two windows and out_ready=1 → the second window is accepted exactly LEN+2 cycles after the first, and both results are correct and in order.

Source files
------------

// File: rtl/conv_mac.sv
// conv_mac: serial dot product of a captured LEN-tap window and kernel.
// One multiply-accumulate per cycle through a single shared multiplier.
// Windows are not overlapped: a new window is taken only after the previous
// result has been handed to the sink.
module conv_mac #(
    parameter int LEN       = 8,
    parameter int WIDTH     = 16,
    parameter int RES_WIDTH = 2*WIDTH + $clog2(LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN*WIDTH-1:0] in_data,
    input  logic [LEN*WIDTH-1:0] kernel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [RES_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Captured operands; same element packing as the input ports.
    logic [LEN-1:0][WIDTH-1:0] win;
    logic [LEN-1:0][WIDTH-1:0] kern;

    logic [CNT_W-1:0]     cnt;
    logic [RES_WIDTH-1:0] acc;
    logic [2*WIDTH-1:0]   prod;
    logic [RES_WIDTH-1:0] prod_ext;
    logic [RES_WIDTH-1:0] acc_nxt;
    logic                 last_tap;

    // Shared multiplier and accumulator adder for the tap selected by cnt.
    always_comb begin
        prod     = win[cnt] * kern[cnt];
        prod_ext = RES_WIDTH'(prod);
        acc_nxt  = acc + prod_ext;
        last_tap = (cnt == CNT_W'(LEN-1));
    end

    // Next-state: accept in IDLE, step taps in CALC, wait for sink in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_tap)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Accumulator, tap counter and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    // Counter parks on the last tap instead of wrapping.
                    if (!last_tap) cnt <= cnt + 1'b1;
                    else           out_data <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    // Operand capture on acceptance; contents are only read during CALC,
    // so these wide registers carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            win  <= in_data;
            kern <= kernel;
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: directed stimulus with a transaction-level reference model
// and a per-cycle compare process.
module tb_conv_mac;

    localparam int LEN   = 8;
    localparam int WIDTH = 16;
    localparam int RW    = 2*WIDTH + $clog2(LEN);

    logic                 clk;
    logic                 rst;
    logic [LEN*WIDTH-1:0] in_data;
    logic [LEN*WIDTH-1:0] kernel;
    logic                 in_valid;
    logic                 in_ready;
    logic [RW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;

    conv_mac #(.LEN(LEN), .WIDTH(WIDTH), .RES_WIDTH(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .kernel    (kernel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [RW-1:0] dot(input logic [LEN*WIDTH-1:0] d, input logic [LEN*WIDTH-1:0] k);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < LEN; i++)
            s += 64'(d[i*WIDTH +: WIDTH]) * 64'(k[i*WIDTH +: WIDTH]);
        return s[RW-1:0];
    endfunction

    // Reference model: a window taken while idle yields its dot product
    // LEN edges later and is presented until the sink takes it.
    int            cyc     = 0;
    int            m_phase = 0;   // 0 idle, 1 computing, 2 presenting
    int            m_left  = 0;
    logic [RW-1:0] m_res   = '0;
    logic [RW-1:0] m_out   = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_left  = 0;
            m_out   = '0;
        end else begin
            cyc++;
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = dot(in_data, kernel);
                    m_left  = LEN;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_out   = m_res;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare against the model, plus a log of delivered results.
    logic [RW-1:0] dut_q[$];

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
            chk("out_data", 64'(out_data), 64'(m_out));
            chk("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
            if (out_valid && out_ready) dut_q.push_back(out_data);
        end
    end

    task automatic wait_out_valid(input string nm);
        int n = 0;
        while (out_valid !== 1'b1 && n < 4*LEN) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) chk({nm, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_in_ready(input string nm);
        int n = 0;
        while (in_ready !== 1'b1 && n < 4*LEN) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk({nm, "_timeout"}, 64'(in_ready), 64'd1);
    endtask

    logic [LEN-1:0][WIDTH-1:0] w, k;
    int a1, a2;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        kernel    = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic: 1..8 with unit kernel.
        for (int i = 0; i < LEN; i++) begin w[i] = 16'(i+1); k[i] = 16'd1; end
        in_data = w; kernel = k; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a1 = cyc;
        chk("basic_accepted", 64'(in_ready), 64'd0);
        wait_out_valid("basic");
        chk("basic_latency", 64'(cyc - a1), 64'(LEN));
        chk("basic_result", 64'(out_data), 64'd36);
        chk("basic_model_pin", 64'(m_out), 64'd36);
        @(negedge clk);
        chk("basic_ready_after", 64'(in_ready), 64'd1);

        // Full-scale operands.
        for (int i = 0; i < LEN; i++) begin w[i] = 16'hFFFF; k[i] = 16'hFFFF; end
        in_data = w; kernel = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("full");
        chk("full_result", 64'(out_data), 64'h7_FFF0_0008);
        @(negedge clk);

        // Backpressure: result held for 10 cycles.
        w = '0; k = '0;
        w[0] = 16'd2; w[7] = 16'd3; k[0] = 16'd5; k[7] = 16'd7;
        in_data = w; kernel = k; out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("bp");
        chk("bp_result", 64'(out_data), 64'd31);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_data", 64'(out_data), 64'd31);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);

        // Inputs change after acceptance; in_valid asserted during CALC/DONE.
        for (int i = 0; i < LEN; i++) begin w[i] = 16'(i+1); k[i] = 16'(LEN-i); end
        in_data = w; kernel = k; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_data = {LEN{16'hAAAA}};
        kernel  = {LEN{16'hAAAA}};
        wait_out_valid("chg");
        @(negedge clk);
        chk("chg_no_accept", 64'(in_ready), 64'd0);
        chk("chg_result", 64'(out_data), 64'd120);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("chg_release_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Reset in the middle of CALC.
        for (int i = 0; i < LEN; i++) begin w[i] = 16'(i+1); k[i] = 16'd1; end
        in_data = w; kernel = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LEN; i++) begin w[i] = 16'd2; k[i] = 16'd3; end
        in_data = w; kernel = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("after_rst");
        chk("after_rst_result", 64'(out_data), 64'd48);
        @(negedge clk);

        // Back-to-back windows with in_valid held high.
        dut_q.delete();
        for (int i = 0; i < LEN; i++) begin w[i] = 16'd1; k[i] = 16'd1; end
        in_data = w; kernel = k; in_valid = 1'b1;
        @(negedge clk);
        a1 = cyc;
        chk("b2b_first_accept", 64'(in_ready), 64'd0);
        for (int i = 0; i < LEN; i++) begin w[i] = 16'(i+1); k[i] = 16'd2; end
        in_data = w; kernel = k;
        wait_in_ready("b2b");
        @(negedge clk);
        a2 = cyc;
        in_valid = 1'b0;
        chk("b2b_second_accept", 64'(in_ready), 64'd0);
        chk("b2b_spacing", 64'(a2 - a1), 64'(LEN + 2));
        wait_out_valid("b2b2");
        repeat (2) @(negedge clk);
        chk("b2b_count", 64'(dut_q.size()), 64'd2);
        if (dut_q.size() == 2) begin
            chk("b2b_res0", 64'(dut_q[0]), 64'd8);
            chk("b2b_res1", 64'(dut_q[1]), 64'd72);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
